instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter CNT_W, default 16: width of the two saturating statistics counters.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  request fields valid this cycle.
REQ-005 in_ready  output  1  encoder can accept a request this cycle.
REQ-006 in_opcode  input  7  RV32I opcode, compared against the `ITYPE/`STORE/`LOAD/`SBTYPE/`JAL/`JALR/`AUIPC/`LUI macros from parameters.vh, plus R-type 7'b0110011.
REQ-007 in_rd, in_rs1, in_rs2  input  5 each  register fields.
REQ-008 in_funct3  input  3; in_funct7  input  7  function fields.
REQ-009 in_imm  input  32  full-width immediate value, i.e. the value the decoder regenerates.
REQ-010 out_valid  output  1  out_instr/out_err hold a result.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_instr  output  32  encoded instruction word.
REQ-013 out_err  output  2  00 ok, 01 immediate out of range, 10 misaligned, 11 illegal opcode.
REQ-014 enc_count, err_count  output  CNT_W each  accepted requests; accepted requests with out_err != 00.

Function
REQ-015 The block SHALL be a single registered stage: in_ready = !out_valid || out_ready; a request transfers when in_valid && in_ready.
REQ-016 Latency SHALL be 1 cycle: a transfer at edge N makes out_valid=1 with the result after edge N.
REQ-017 out_valid SHALL clear after an edge where out_valid && out_ready and no new transfer occurs; a simultaneous pop and push SHALL load the new result with no bubble.
REQ-018 out_instr/out_err SHALL hold stable while out_valid && !out_ready.
REQ-019 ITYPE (funct3 not 001/101), LOAD, JALR: range ok iff in_imm[31:11] all equal; word = {imm[11:0], rs1, funct3, rd, opcode}.
REQ-020 ITYPE shift (funct3 001 or 101): range ok iff in_imm[31:5]==0; word = {funct7, imm[4:0], rs1, funct3, rd, opcode}.
REQ-021 STORE: range as REQ-019; word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-022 SBTYPE: range ok iff in_imm[31:12] all equal; aligned iff in_imm[0]==0; word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
REQ-023 JAL: range ok iff in_imm[31:20] all equal; aligned iff in_imm[0]==0; word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-024 LUI, AUIPC: aligned iff in_imm[11:0]==0 (code 10 otherwise); word = {imm[31:12], rd, opcode}.
REQ-025 R-type: word = {funct7, rs2, rs1, funct3, rd, opcode}; in_imm ignored; never errors except as below.
REQ-026 Any other opcode SHALL give out_err=11.
REQ-027 Error priority SHALL be 11 > 10 > 01; on any error out_instr SHALL be 32'h00000013 (NOP).
REQ-028 enc_count SHALL increment on every transfer, err_count on every transfer with error; both SHALL saturate at all-ones, no wrap.
REQ-029 For every error-free non-R-type result, decoding out_instr's immediate per the codebase's immediate-generation rules SHALL reproduce in_imm exactly (in_imm[4:0] for shifts).

Reset
REQ-030 rst_n low SHALL immediately force out_valid=0, out_instr=0, out_err=00, enc_count=0, err_count=0, independent of clk.
REQ-031 in_ready SHALL be 1 during and after reset; a result pending when reset asserts SHALL be discarded.

Verification
REQ-032 ITYPE rd=1 rs1=2 funct3=000 imm=32'hFFFFF800 -> out_instr=32'h80010093, out_err=00, one cycle later.
REQ-033 SBTYPE rs1=1 rs2=2 funct3=000 imm=32'h00000003 -> out_err=10, out_instr=32'h00000013, err_count+1; imm=32'h00001000 -> out_err=01.
REQ-034 JAL rd=1 imm=32'hFFFFFFFE -> out_instr=32'hFFFFF0EF; LUI rd=5 imm=32'h12345000 -> 32'h123452B7.
REQ-035 Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, output stable; then back-to-back transfers with out_ready=1 -> one result per cycle, no loss or duplication.
REQ-036 Assert rst_n low mid-stream with out_valid=1 -> out_valid and counters 0 before next edge; opcode 7'b1111111 after reset -> out_err=11.
REQ-037 Random legal requests looped through the immediate generator -> regenerated immediate equals in_imm for all error-free cases.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: single-stage RV32I instruction encoder with
// range/alignment/opcode checking and saturating statistics counters.
module instr_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [1:0]       out_err,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_SBTYPE = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [31:0] NOP_WORD = 32'h00000013;

    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_instr_q, out_instr_d;
    logic [1:0]       out_err_q, out_err_d;
    logic [CNT_W-1:0] enc_count_q, enc_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    logic        xfer;
    logic [31:0] raw_word;
    logic [31:0] enc_word;
    logic [1:0]  enc_err;
    logic        illegal;
    logic        misaligned;
    logic        range_bad;
    logic        fits12;
    logic        fits13;
    logic        fits21;

    assign in_ready  = !out_valid_q || out_ready;
    assign xfer      = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_err   = out_err_q;
    assign enc_count = enc_count_q;
    assign err_count = err_count_q;

    // Signed-fit tests: upper bits must all be copies of the sign bit.
    assign fits12 = (&in_imm[31:11]) || !(|in_imm[31:11]);
    assign fits13 = (&in_imm[31:12]) || !(|in_imm[31:12]);
    assign fits21 = (&in_imm[31:20]) || !(|in_imm[31:20]);

    // Pack the request into its format and flag illegal/misaligned/out-of-range cases.
    always_comb begin
        raw_word   = NOP_WORD;
        illegal    = 1'b0;
        misaligned = 1'b0;
        range_bad  = 1'b0;
        case (in_opcode)
            OP_ITYPE: begin
                if (in_funct3 == 3'b001 || in_funct3 == 3'b101) begin
                    range_bad = |in_imm[31:5];
                    raw_word  = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
                end else begin
                    range_bad = !fits12;
                    raw_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                end
            end
            OP_LOAD, OP_JALR: begin
                range_bad = !fits12;
                raw_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            end
            OP_STORE: begin
                range_bad = !fits12;
                raw_word  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            end
            OP_SBTYPE: begin
                range_bad  = !fits13;
                misaligned = in_imm[0];
                raw_word   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                              in_imm[4:1], in_imm[11], in_opcode};
            end
            OP_JAL: begin
                range_bad  = !fits21;
                misaligned = in_imm[0];
                raw_word   = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
            end
            OP_LUI, OP_AUIPC: begin
                misaligned = |in_imm[11:0];
                raw_word   = {in_imm[31:12], in_rd, in_opcode};
            end
            OP_RTYPE: begin
                raw_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    // Resolve error priority (illegal > misaligned > range); any error yields a NOP word.
    always_comb begin
        enc_err  = 2'b00;
        enc_word = raw_word;
        if (illegal) begin
            enc_err = 2'b11;
        end else if (misaligned) begin
            enc_err = 2'b10;
        end else if (range_bad) begin
            enc_err = 2'b01;
        end
        if (enc_err != 2'b00) begin
            enc_word = NOP_WORD;
        end
    end

    // Output stage and statistics: load on transfer, drain on pop, hold otherwise.
    always_comb begin
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_err_d   = out_err_q;
        enc_count_d = enc_count_q;
        err_count_d = err_count_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_instr_d = enc_word;
            out_err_d   = enc_err;
            if (enc_count_q != {CNT_W{1'b1}}) begin
                enc_count_d = enc_count_q + CNT_W'(1);
            end
            if (enc_err != 2'b00 && err_count_q != {CNT_W{1'b1}}) begin
                err_count_d = err_count_q + CNT_W'(1);
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State register with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_instr_q <= 32'h0;
            out_err_q   <= 2'b00;
            enc_count_q <= '0;
            err_count_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_err_q   <= out_err_d;
            enc_count_q <= enc_count_d;
            err_count_q <= err_count_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and randomized checks of instr_encoder against
// a queue-based reference model built from the encoding rules.
module tb_instr_encoder;

    localparam int CNT_W = 4;

    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_SBTYPE = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [6:0]       in_opcode;
    logic [4:0]       in_rd, in_rs1, in_rs2;
    logic [2:0]       in_funct3;
    logic [6:0]       in_funct7;
    logic [31:0]      in_imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic [1:0]       out_err;
    logic [CNT_W-1:0] enc_count;
    logic [CNT_W-1:0] err_count;

    typedef struct {
        logic [31:0] word;
        logic [1:0]  err;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] imm;
    } entry_t;

    entry_t expQ[$];
    int     encCnt;
    int     errCnt;
    int     passCount;
    int     checkCount;

    instr_encoder #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .enc_count (enc_count),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // True when the immediate is representable as a signed value of the given width.
    function automatic bit fitsSigned(logic [31:0] v, int bits);
        longint s;
        longint lim;
        s   = longint'($signed(v));
        lim = longint'(1) << (bits - 1);
        return (s >= -lim) && (s < lim);
    endfunction

    function automatic bit isShift(logic [6:0] op, logic [2:0] f3);
        return op == OP_ITYPE && (f3 == 3'd1 || f3 == 3'd5);
    endfunction

    // Reference encoding: classify the request, then place fields by format.
    function automatic entry_t refEncode(logic [6:0] op, logic [4:0] rd, logic [4:0] rs1,
                                         logic [4:0] rs2, logic [2:0] f3, logic [6:0] f7,
                                         logic [31:0] imm);
        entry_t e;
        bit legal;
        bit aligned;
        bit inRange;
        legal   = 1'b1;
        aligned = 1'b1;
        inRange = 1'b1;
        e.op  = op;
        e.f3  = f3;
        e.imm = imm;
        e.word = 32'h00000013;
        if (isShift(op, f3)) begin
            inRange = imm < 32;
            e.word  = {f7, imm[4:0], rs1, f3, rd, op};
        end else if (op == OP_ITYPE || op == OP_LOAD || op == OP_JALR) begin
            inRange = fitsSigned(imm, 12);
            e.word  = {imm[11:0], rs1, f3, rd, op};
        end else if (op == OP_STORE) begin
            inRange = fitsSigned(imm, 12);
            e.word  = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
        end else if (op == OP_SBTYPE) begin
            inRange = fitsSigned(imm, 13);
            aligned = (imm % 2) == 0;
            e.word  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        end else if (op == OP_JAL) begin
            inRange = fitsSigned(imm, 21);
            aligned = (imm % 2) == 0;
            e.word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        end else if (op == OP_LUI || op == OP_AUIPC) begin
            aligned = (imm % 4096) == 0;
            e.word  = {imm[31:12], rd, op};
        end else if (op == OP_RTYPE) begin
            e.word  = {f7, rs2, rs1, f3, rd, op};
        end else begin
            legal = 1'b0;
        end
        if (!legal)        e.err = 2'b11;
        else if (!aligned) e.err = 2'b10;
        else if (!inRange) e.err = 2'b01;
        else               e.err = 2'b00;
        if (e.err != 2'b00) e.word = 32'h00000013;
        return e;
    endfunction

    // Immediate generation as a decoder would do it, from the encoded word.
    function automatic logic [31:0] regenImm(logic [31:0] w, logic [6:0] op, logic [2:0] f3);
        if (isShift(op, f3))                                   return {27'b0, w[24:20]};
        if (op == OP_ITYPE || op == OP_LOAD || op == OP_JALR)   return {{20{w[31]}}, w[31:20]};
        if (op == OP_STORE)                                     return {{20{w[31]}}, w[31:25], w[11:7]};
        if (op == OP_SBTYPE)  return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        if (op == OP_JAL)     return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        return {w[31:12], 12'b0};
    endfunction

    function automatic int sat(int v);
        return (v > (2**CNT_W - 1)) ? (2**CNT_W - 1) : v;
    endfunction

    task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    // One cycle: drive request, check outputs against the model, advance over an edge.
    task automatic applyStimulus(logic v, logic rdy, logic [6:0] op, logic [4:0] rd,
                                 logic [4:0] rs1, logic [4:0] rs2, logic [2:0] f3,
                                 logic [6:0] f7, logic [31:0] imm);
        bit pop;
        bit push;
        entry_t e;
        in_valid  = v;
        out_ready = rdy;
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
        #1;
        checkOutput("in_ready", 32'(in_ready), 32'(expQ.size() == 0 || rdy));
        checkOutput("out_valid", 32'(out_valid), 32'(expQ.size() != 0));
        if (expQ.size() != 0) begin
            checkOutput("out_instr", out_instr, expQ[0].word);
            checkOutput("out_err", 32'(out_err), 32'(expQ[0].err));
            if (expQ[0].err == 2'b00 && expQ[0].op != OP_RTYPE) begin
                checkOutput("imm_regen", regenImm(out_instr, expQ[0].op, expQ[0].f3), expQ[0].imm);
            end
        end
        pop  = (expQ.size() != 0) && rdy;
        push = v && (expQ.size() == 0 || rdy);
        e    = refEncode(op, rd, rs1, rs2, f3, f7, imm);
        @(posedge clk);
        if (pop) void'(expQ.pop_front());
        if (push) begin
            expQ.push_back(e);
            encCnt++;
            if (e.err != 2'b00) errCnt++;
        end
        @(negedge clk);
        checkOutput("enc_count", 32'(enc_count), 32'(sat(encCnt)));
        checkOutput("err_count", 32'(err_count), 32'(sat(errCnt)));
    endtask

    // Random immediates biased toward each format's legal range.
    function automatic logic [31:0] randImm();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0: return r;
            1: return {{20{r[11]}}, r[11:0]};
            2: return {{19{r[12]}}, r[12:1], 1'b0};
            3: return {{11{r[20]}}, r[20:1], 1'b0};
            4: return {r[31:12], 12'b0};
            default: return {27'b0, r[4:0]};
        endcase
    endfunction

    function automatic logic [6:0] randOp();
        logic [6:0] ops [9];
        ops = '{OP_ITYPE, OP_LOAD, OP_STORE, OP_SBTYPE, OP_JAL, OP_JALR, OP_AUIPC, OP_LUI, OP_RTYPE};
        if ($urandom_range(0, 9) == 9) return 7'($urandom);
        return ops[$urandom_range(0, 8)];
    endfunction

    initial begin
        passCount  = 0;
        checkCount = 0;
        encCnt     = 0;
        errCnt     = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        in_opcode  = '0;
        in_rd      = '0;
        in_rs1     = '0;
        in_rs2     = '0;
        in_funct3  = '0;
        in_funct7  = '0;
        in_imm     = '0;

        @(negedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_instr", out_instr, 32'd0);
        checkOutput("rst_out_err", 32'(out_err), 32'd0);
        checkOutput("rst_enc_count", 32'(enc_count), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed vectors");
        applyStimulus(1, 1, OP_ITYPE, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFFF800);
        checkOutput("itype_instr", out_instr, 32'h80010093);
        checkOutput("itype_err", 32'(out_err), 32'd0);
        applyStimulus(1, 1, OP_SBTYPE, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h00000003);
        checkOutput("br_misalign_err", 32'(out_err), 32'd2);
        checkOutput("br_misalign_nop", out_instr, 32'h00000013);
        checkOutput("br_misalign_errcnt", 32'(err_count), 32'd1);
        applyStimulus(1, 1, OP_SBTYPE, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h00001000);
        checkOutput("br_range_err", 32'(out_err), 32'd1);
        applyStimulus(1, 1, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFE);
        checkOutput("jal_instr", out_instr, 32'hFFFFF0EF);
        applyStimulus(1, 1, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
        checkOutput("lui_instr", out_instr, 32'h123452B7);

        $display("[TB] backpressure hold then back-to-back");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, OP_RTYPE, 5'd3, 5'd4, 5'd5, 3'd0, 7'h20, 32'h0);
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 1, OP_ITYPE, 5'(i), 5'(i + 1), 5'd0, 3'd0, 7'd0, 32'(i * 3));
        end

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), randOp(),
                          5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom),
                          randImm());
        end

        $display("[TB] reset mid-stream");
        applyStimulus(1, 0, OP_LUI, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE000);
        applyStimulus(1, 0, OP_LUI, 5'd8, 5'd0, 5'd0, 3'd0, 7'd0, 32'h11111000);
        checkOutput("pre_reset_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("async_rst_instr", out_instr, 32'd0);
        checkOutput("async_rst_enc", 32'(enc_count), 32'd0);
        checkOutput("async_rst_err", 32'(err_count), 32'd0);
        checkOutput("async_rst_ready", 32'(in_ready), 32'd1);
        expQ.delete();
        encCnt = 0;
        errCnt = 0;
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1, 1, 7'b1111111, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'h0);
        checkOutput("illegal_err", 32'(out_err), 32'd3);
        applyStimulus(0, 1, OP_RTYPE, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0);
        applyStimulus(0, 1, OP_RTYPE, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
